// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the shared register-file write port
module regfile_wb_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_data,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          fwd_a,
    output logic          fwd_b,
    output logic [CW-1:0] conflict_cnt
);

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_t;

    prio_t prio_q;
    prio_t prio_d;
    logic  alu_grant;
    logic  mem_grant;
    logic  any_grant;
    logic  conflict;

    // Grant decision: depends only on valids, priority pointer, stall and reset
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!rst && !stall) begin
            if (alu_valid && (!mem_valid || prio_q == PRIO_ALU)) begin
                alu_grant = 1'b1;
            end else if (mem_valid) begin
                mem_grant = 1'b1;
            end
        end
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;
    assign any_grant = alu_grant | mem_grant;
    assign conflict  = alu_valid & mem_valid & ~stall;

    // Next priority: the side that just lost (or did not ask) goes first next time
    always_comb begin
        prio_d = prio_q;
        if (alu_grant) begin
            prio_d = PRIO_MEM;
        end else if (mem_grant) begin
            prio_d = PRIO_ALU;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Output stage: advances when not stalled, a held write is dropped by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else if (!stall) begin
            rf_we <= any_grant;
            if (alu_grant) begin
                rf_rd   <= alu_rd;
                rf_data <= alu_data;
            end else if (mem_grant) begin
                rf_rd   <= mem_rd;
                rf_data <= mem_data;
            end
        end
    end

    // Saturating count of unstalled cycles with both requesters valid
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && conflict_cnt != {CW{1'b1}}) begin
            conflict_cnt <= conflict_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Bypass flags for decode: hit on the write currently in the output register
    assign fwd_a = rf_we && (rf_rd == rs);
    assign fwd_b = rf_we && (rf_rd == rt);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, stall;
    logic [3:0]  alu_rd, mem_rd, rs, rt;
    logic [15:0] alu_data, mem_data;

    logic        alu_ready, mem_ready, rf_we, fwd_a, fwd_b;
    logic [3:0]  rf_rd;
    logic [15:0] rf_data;
    logic [7:0]  conflict_cnt;

    logic        alu_ready_s, mem_ready_s, rf_we_s, fwd_a_s, fwd_b_s;
    logic [3:0]  rf_rd_s;
    logic [15:0] rf_data_s;
    logic [1:0]  conflict_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DW(16), .AW(4), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .stall(stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .rs(rs), .rt(rt), .fwd_a(fwd_a), .fwd_b(fwd_b), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.DW(16), .AW(4), .CW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready_s),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready_s),
        .stall(stall), .rf_we(rf_we_s), .rf_rd(rf_rd_s), .rf_data(rf_data_s),
        .rs(rs), .rt(rt), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .conflict_cnt(conflict_cnt_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_alu [4];
        exp_alu = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1; stall = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'h0;
        mem_valid = 1'b0; mem_rd = 4'd0; mem_data = 16'h0;
        rs = 4'd0; rt = 4'd0;

        // Reset with a pending ALU request
        step();
        step();
        check_eq("rst_alu_ready", alu_ready, 0);
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_rf_rd", rf_rd, 0);
        check_eq("rst_rf_data", rf_data, 0);
        check_eq("rst_cnt", conflict_cnt, 0);
        check_eq("rst_fwd_a", fwd_a, 0);

        rst = 1'b0; alu_valid = 1'b0;
        step();

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 16'hAAAA;
        #1;
        check_eq("single_alu_ready", alu_ready, 1);
        check_eq("single_mem_ready", mem_ready, 0);
        step();
        alu_valid = 1'b0;
        check_eq("single_rf_we", rf_we, 1);
        check_eq("single_rf_rd", rf_rd, 2);
        check_eq("single_rf_data", rf_data, 16'hAAAA);
        step();
        check_eq("single_we_drop", rf_we, 0);
        check_eq("single_rd_keep", rf_rd, 2);

        // MEM-only write hands priority back to ALU
        mem_valid = 1'b1; mem_rd = 4'd9; mem_data = 16'h1234;
        #1;
        check_eq("memonly_ready", mem_ready, 1);
        step();
        check_eq("memonly_rf_rd", rf_rd, 9);
        check_eq("memonly_rf_data", rf_data, 16'h1234);

        // Conflict round-robin: ALU, MEM, ALU, MEM
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_rd = 4'd3; mem_data = 16'h3333;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("rr_alu_ready", alu_ready, exp_alu[i][0]);
            check_eq("rr_mem_ready", mem_ready, exp_alu[i][1]);
            step();
            check_eq("rr_rf_rd", rf_rd, exp_alu[i][0] ? 32'd1 : 32'd3);
            check_eq("rr_rf_data", rf_data, exp_alu[i][0] ? 32'h1111 : 32'h3333);
        end
        check_eq("rr_cnt", conflict_cnt, 4);
        check_eq("rr_cnt_sat", conflict_cnt_s, 3);

        // Stall hold after a MEM write
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 16'h0F0F;
        #1;
        check_eq("stall_mem_ready", mem_ready, 1);
        step();
        stall = 1'b1;
        alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 16'hBEEF;
        mem_rd = 4'd6; mem_data = 16'h6666;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_alu_ready", alu_ready, 0);
            check_eq("stall_mem_ready0", mem_ready, 0);
            step();
            check_eq("stall_rf_we", rf_we, 1);
            check_eq("stall_rf_rd", rf_rd, 5);
            check_eq("stall_rf_data", rf_data, 16'h0F0F);
        end
        check_eq("stall_cnt_frozen", conflict_cnt, 4);
        stall = 1'b0;
        #1;
        check_eq("release_alu_ready", alu_ready, 1);
        check_eq("release_mem_ready", mem_ready, 0);
        step();
        check_eq("release_rf_rd", rf_rd, 4);
        check_eq("release_rf_data", rf_data, 16'hBEEF);
        check_eq("release_cnt", conflict_cnt, 5);
        check_eq("sat_cnt", conflict_cnt_s, 3);

        // Forwarding against a held write to r7
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h7777;
        step();
        alu_valid = 1'b0; stall = 1'b1;
        rs = 4'd7; rt = 4'd6;
        #1;
        check_eq("fwd_a_hit", fwd_a, 1);
        check_eq("fwd_b_miss", fwd_b, 0);
        rs = 4'd6; rt = 4'd7;
        #1;
        check_eq("fwd_a_miss", fwd_a, 0);
        check_eq("fwd_b_hit", fwd_b, 1);
        stall = 1'b0;
        step();
        rs = 4'd7; rt = 4'd7;
        #1;
        check_eq("fwd_idle_we", rf_we, 0);
        check_eq("fwd_idle_a", fwd_a, 0);
        check_eq("fwd_idle_b", fwd_b, 0);

        // Reset during a stalled write; ALU grant first leaves prio pointing at MEM
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h5555;
        step();
        alu_valid = 1'b0; stall = 1'b1;
        step();
        check_eq("held_rf_we", rf_we, 1);
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_rd = 4'd3; mem_data = 16'h3333;
        stall = 1'b0;
        #1;
        check_eq("inrst_alu_ready", alu_ready, 0);
        check_eq("inrst_mem_ready", mem_ready, 0);
        stall = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_rf_we", rf_we, 0);
        check_eq("midrst_rf_rd", rf_rd, 0);
        check_eq("midrst_rf_data", rf_data, 0);
        check_eq("midrst_cnt", conflict_cnt, 0);
        check_eq("midrst_cnt_sat", conflict_cnt_s, 0);
        check_eq("midrst_fwd_a", fwd_a, 0);
        stall = 1'b0;
        #1;
        check_eq("postrst_alu_ready", alu_ready, 1);
        check_eq("postrst_mem_ready", mem_ready, 0);
        step();
        check_eq("postrst_rf_rd", rf_rd, 1);
        check_eq("postrst_rf_data", rf_data, 16'h1111);
        check_eq("postrst_cnt", conflict_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
